manchester_deframer: RTL and testbench

//  Receive-side counterpart of the Manchester TX chain (framer/escape/preamble/serializer).

---
 rtl/manchester_deframer.sv | 172 +++++++++++++++++
 tb/tb_manchester_deframer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_deframer.sv
// Receive deframer: hunts preamble + SOF, strips escapes, emits each payload as AXI-Stream with tlast/tuser.
// Define RX_STATS_EN to build the good-frame / error-event counters; otherwise both count ports read 0.
module manchester_deframer #(
  parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
  parameter int         MIN_PREAMBLE  = 2,
  parameter logic [7:0] SOF_BYTE      = 8'hD5,
  parameter logic [7:0] EOF_BYTE      = 8'h7E,
  parameter logic [7:0] ESC_BYTE      = 8'h7D,
  parameter logic [7:0] ESC_XOR       = 8'h20,
  parameter int         MAX_FRAME_LEN = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        rx_error,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt
);

  localparam int               LEN_W      = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_FRAME_LEN);
  localparam logic [4:0]       PRE_TARGET = 5'(MIN_PREAMBLE);

  typedef enum logic [1:0] {HUNT, SOF_WAIT, DATA, ESC} state_t;

  state_t           state;
  logic [3:0]       pre_cnt;
  logic [LEN_W-1:0] len;
  logic             hold_full;
  logic [7:0]       hold_data;

  logic       consume;
  logic       ev_payload, ev_eof, ev_abort;
  logic       ev_overflow, ev_push, ev_last, ev_err;
  logic [7:0] pay_byte;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign consume       = s_axis_tvalid && s_axis_tready;

  // Classify the consumed byte inside a frame; an escaped EOF aborts instead of becoming data.
  always_comb begin
    ev_payload = 1'b0;
    ev_eof     = 1'b0;
    ev_abort   = 1'b0;
    pay_byte   = s_axis_tdata;
    if (consume) begin
      case (state)
        DATA: begin
          if (s_axis_tdata == EOF_BYTE)      ev_eof     = 1'b1;
          else if (s_axis_tdata == SOF_BYTE) ev_abort   = 1'b1;
          else if (s_axis_tdata != ESC_BYTE) ev_payload = 1'b1;
        end
        ESC: begin
          if (s_axis_tdata == EOF_BYTE) ev_abort = 1'b1;
          else begin
            ev_payload = 1'b1;
            pay_byte   = s_axis_tdata ^ ESC_XOR;
          end
        end
        default: ;
      endcase
    end
  end

  assign ev_overflow = ev_payload && (len == LEN_MAX);
  assign ev_push     = ev_payload && !ev_overflow && hold_full;
  assign ev_last     = (ev_eof || ev_abort || ev_overflow) && hold_full;
  assign ev_err      = (ev_eof && !hold_full) || ev_abort || ev_overflow;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= HUNT;
      pre_cnt       <= '0;
      len           <= '0;
      hold_full     <= 1'b0;
      hold_data     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      rx_error <= ev_err;
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      // The held byte leaves only when its successor or a terminator arrives, so tlast lands on it.
      if (ev_push || ev_last) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= hold_data;
        m_axis_tlast  <= ev_last;
        m_axis_tuser  <= ev_last && !ev_eof;
      end
      if (consume) begin
        case (state)
          HUNT: begin
            if (s_axis_tdata == PREAMBLE_BYTE) begin
              if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
              if ({1'b0, pre_cnt} + 5'd1 >= PRE_TARGET) state <= SOF_WAIT;
            end else begin
              pre_cnt <= '0;
            end
          end
          SOF_WAIT: begin
            if (s_axis_tdata == SOF_BYTE) begin
              state     <= DATA;
              len       <= '0;
              hold_full <= 1'b0;
              pre_cnt   <= '0;
            end else if (s_axis_tdata != PREAMBLE_BYTE) begin
              state   <= HUNT;
              pre_cnt <= '0;
            end
          end
          DATA: begin
            if (s_axis_tdata == ESC_BYTE) begin
              state <= ESC;
            end else if (s_axis_tdata == EOF_BYTE) begin
              state     <= HUNT;
              hold_full <= 1'b0;
            end else if (s_axis_tdata == SOF_BYTE) begin
              len       <= '0;
              hold_full <= 1'b0;
            end
          end
          ESC: begin
            if (s_axis_tdata == EOF_BYTE) begin
              state     <= HUNT;
              hold_full <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        endcase
        if (ev_payload) begin
          if (ev_overflow) begin
            state     <= HUNT;
            hold_full <= 1'b0;
          end else begin
            len       <= len + 1'b1;
            hold_data <= pay_byte;
            hold_full <= 1'b1;
          end
        end
      end
    end
  end

`ifdef RX_STATS_EN
  logic ev_good;
  assign ev_good = ev_eof && hold_full;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_ok_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      if (ev_good) frame_ok_cnt  <= frame_ok_cnt + 16'd1;
      if (ev_err)  frame_err_cnt <= frame_err_cnt + 16'd1;
    end
  end
`else
  assign frame_ok_cnt  = 16'h0000;
  assign frame_err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_manchester_deframer.sv
// Bench for manchester_deframer: fixed vectors, hand-written latency/reset sequences and a
// randomized stream checked against a frame-level reference model.
module tb_manchester_deframer;

  localparam int         MAX_LEN = 4;
  localparam int         MIN_PRE = 2;
  localparam logic [7:0] PRE     = 8'h55;
  localparam logic [7:0] SOF     = 8'hD5;
  localparam logic [7:0] EOFB    = 8'h7E;
  localparam logic [7:0] ESCB    = 8'h7D;
  localparam logic [7:0] XORM    = 8'h20;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        rx_error;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  manchester_deframer #(.MAX_FRAME_LEN(MAX_LEN), .MIN_PREAMBLE(MIN_PRE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .rx_error(rx_error),
    .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int exp_err = 0;
  int exp_ok = 0;
  logic [9:0]  got_q[$];
  logic [9:0]  exp_q[$];
  logic [7:0]  stim_q[$];
  logic [7:0]  mpay[$];
  logic        prev_stall = 1'b0;
  logic [10:0] prev_out = '0;

  // Beats are packed as {tuser, tlast, tdata}.
  typedef struct packed {
    logic [7:0]   n_in;
    logic [127:0] in_b;
    logic [3:0]   n_out;
    logic [59:0]  out_b;
    logic [3:0]   n_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic sv, input logic [7:0] sd, input logic mr, output logic consumed);
    @(negedge aclk);
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    m_axis_tready = mr;
    #1;
    if (prev_stall)
      check_output("hold_stable", int'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), int'(prev_out));
    check_output("s_tready", int'(s_axis_tready), int'(!m_axis_tvalid || m_axis_tready));
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_out   = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
    if (rx_error) err_seen++;
    consumed = sv && s_axis_tready;
  endtask

  task automatic idle(input int n, input bit rnd);
    logic c;
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, rnd ? ($urandom_range(0, 9) < 7) : 1'b1, c);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    logic c;
    int tries;
    c = 1'b0;
    tries = 0;
    if (rnd && $urandom_range(0, 3) == 0) idle(1, 1'b1);
    while (!c) begin
      if (tries == 200) begin
        total++;
        bad++;
        $display("[TB] FAIL send_timeout: byte 0x%0h not accepted after %0d cycles, required acceptance", b, tries);
        return;
      end
      step(1'b1, b, rnd ? ($urandom_range(0, 9) < 7) : 1'b1, c);
      tries++;
    end
  endtask

  task automatic apply_stimulus(input bit rnd);
    for (int k = 0; k < stim_q.size(); k++) send_byte(stim_q[k], rnd);
    idle(8, 1'b0);
  endtask

  task automatic compare_run(input string name);
    check_output({name, "_beats"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check_output($sformatf("%s_beat%0d", name, k), int'(got_q[k]), int'(exp_q[k]));
    check_output({name, "_errs"}, err_seen, exp_err);
  endtask

  function automatic bit pre_run(input int a, input int b);
    for (int k = a; k < b; k++) if (stim_q[k] != PRE) return 1'b0;
    return 1'b1;
  endfunction

  task automatic emit(input bit user);
    for (int k = 0; k < mpay.size(); k++) begin
      bit last;
      last = (k == mpay.size() - 1);
      exp_q.push_back({user && last, last, mpay[k]});
    end
  endtask

  // Frame-level reference: find an SOF preceded by MIN_PRE preambles, collect the unescaped
  // payload until a terminator, then decide how the whole frame is reported.
  task automatic model_run();
    int i, n, start;
    bit found, in_frame;
    logic [7:0] b;
    exp_q.delete();
    exp_err = 0;
    exp_ok = 0;
    n = stim_q.size();
    i = 0;
    while (i < n) begin
      start = i;
      found = 1'b0;
      while (i < n && !found) begin
        if (stim_q[i] == SOF && i - start >= MIN_PRE && pre_run(i - MIN_PRE, i)) found = 1'b1;
        i++;
      end
      if (!found) break;
      mpay.delete();
      in_frame = 1'b1;
      while (in_frame && i < n) begin
        b = stim_q[i];
        i++;
        if (b == EOFB) begin
          if (mpay.size() > 0) begin
            emit(1'b0);
            exp_ok++;
          end else begin
            exp_err++;
          end
          in_frame = 1'b0;
        end else if (b == SOF) begin
          emit(1'b1);
          exp_err++;
          mpay.delete();
        end else begin
          if (b == ESCB) begin
            if (i >= n) break;
            b = stim_q[i];
            i++;
            if (b == EOFB) begin
              emit(1'b1);
              exp_err++;
              in_frame = 1'b0;
              continue;
            end
            b = b ^ XORM;
          end
          if (mpay.size() == MAX_LEN) begin
            emit(1'b1);
            exp_err++;
            in_frame = 1'b0;
          end else begin
            mpay.push_back(b);
          end
        end
      end
      if (in_frame)
        for (int k = 0; k < int'(mpay.size()) - 1; k++) exp_q.push_back({2'b00, mpay[k]});
    end
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0:       return PRE;
      1:       return SOF;
      2:       return EOFB;
      3:       return ESCB;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic c;
    logic [127:0] ib;
    logic [59:0]  ob;
    int ni, no;
    logic [15:0] base_ok, base_err;

    vecs[0] = '{8'd7, 128'({8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h7E}), 4'd3,
                60'({10'h001, 10'h002, 10'h103}), 4'd0};
    vecs[1] = '{8'd8, 128'({8'h55, 8'h55, 8'hD5, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h7E}), 4'd2,
                60'({10'h07E, 10'h17D}), 4'd0};
    vecs[2] = '{8'd6, 128'({8'h55, 8'h55, 8'hD5, 8'h7D, 8'h5D, 8'h7E}), 4'd1, 60'({10'h17D}), 4'd0};
    vecs[3] = '{8'd4, 128'({8'h55, 8'hD5, 8'hAA, 8'h7E}), 4'd0, 60'h0, 4'd0};
    vecs[4] = '{8'd6, 128'({8'h55, 8'h55, 8'h55, 8'hD5, 8'hAA, 8'h7E}), 4'd1, 60'({10'h1AA}), 4'd0};
    vecs[5] = '{8'd8, 128'({8'h55, 8'h55, 8'hD5, 8'h11, 8'h22, 8'hD5, 8'h33, 8'h7E}), 4'd3,
                60'({10'h011, 10'h322, 10'h133}), 4'd1};
    vecs[6] = '{8'd9, 128'({8'h55, 8'h55, 8'hD5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7E}), 4'd4,
                60'({10'h000, 10'h001, 10'h002, 10'h303}), 4'd1};
    vecs[7] = '{8'd4, 128'({8'h55, 8'h55, 8'hD5, 8'h7E}), 4'd0, 60'h0, 4'd1};
    vecs[8] = '{8'd6, 128'({8'h55, 8'h55, 8'hD5, 8'h44, 8'h7D, 8'h7E}), 4'd1, 60'({10'h344}), 4'd1};
    vecs[9] = '{8'd8, 128'({8'h55, 8'h55, 8'hD5, 8'h55, 8'h01, 8'h02, 8'h04, 8'h7E}), 4'd4,
                60'({10'h055, 10'h001, 10'h002, 10'h104}), 4'd0};

    // Reset state
    repeat (3) @(negedge aclk);
    #1;
    check_output("rst_tvalid", int'(m_axis_tvalid), 0);
    check_output("rst_tdata", int'(m_axis_tdata), 0);
    check_output("rst_tlast", int'(m_axis_tlast), 0);
    check_output("rst_tuser", int'(m_axis_tuser), 0);
    check_output("rst_rx_error", int'(rx_error), 0);
    check_output("rst_s_tready", int'(s_axis_tready), 1);
    check_output("rst_ok_cnt", int'(frame_ok_cnt), 0);
    check_output("rst_err_cnt", int'(frame_err_cnt), 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Fixed vectors with downstream always ready
    for (int v = 0; v < 10; v++) begin
      got_q.delete();
      exp_q.delete();
      err_seen = 0;
      ib = vecs[v].in_b;
      ob = vecs[v].out_b;
      ni = int'(vecs[v].n_in);
      no = int'(vecs[v].n_out);
      for (int k = 0; k < ni; k++) send_byte(ib[(ni - 1 - k) * 8 +: 8], 1'b0);
      idle(6, 1'b0);
      for (int k = 0; k < no; k++) exp_q.push_back(ob[(no - 1 - k) * 10 +: 10]);
      exp_err = int'(vecs[v].n_err);
      compare_run($sformatf("vec%0d", v));
    end

    // One-cycle latency from the successor byte / EOF to the held byte
    send_byte(PRE, 1'b0);
    send_byte(PRE, 1'b0);
    send_byte(SOF, 1'b0);
    send_byte(8'hA1, 1'b0);
    step(1'b0, 8'h00, 1'b1, c);
    check_output("lat_held_empty", int'(m_axis_tvalid), 0);
    send_byte(8'hA2, 1'b0);
    step(1'b0, 8'h00, 1'b1, c);
    check_output("lat_a1", int'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), 11'h4A1);
    send_byte(EOFB, 1'b0);
    step(1'b0, 8'h00, 1'b1, c);
    check_output("lat_a2_last", int'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), 11'h5A2);
    idle(4, 1'b0);

    // Reset mid-frame with a beat stalled on the output
    send_byte(PRE, 1'b0);
    send_byte(PRE, 1'b0);
    send_byte(SOF, 1'b0);
    send_byte(8'hB1, 1'b0);
    send_byte(8'hB2, 1'b0);
    step(1'b0, 8'h00, 1'b0, c);
    check_output("mid_stalled", int'({m_axis_tvalid, m_axis_tdata}), 9'h1B1);
    aresetn = 1'b0;
    #1;
    check_output("mid_rst_out", int'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, rx_error}), 0);
    check_output("mid_rst_tready", int'(s_axis_tready), 1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    prev_stall = 1'b0;
    got_q.delete();
    err_seen = 0;
    stim_q = '{EOFB, PRE, PRE, SOF, 8'hC3, EOFB};
    apply_stimulus(1'b0);
    exp_q = '{10'h1C3};
    exp_err = 0;
    compare_run("post_reset");

    // Randomized streams with gappy input and random downstream backpressure
    for (int r = 0; r < 3; r++) begin
      stim_q.delete();
      repeat (40) begin
        repeat ($urandom_range(0, 2)) stim_q.push_back(rand_byte());
        repeat ($urandom_range(1, 3)) stim_q.push_back(PRE);
        stim_q.push_back(SOF);
        repeat ($urandom_range(0, 6)) stim_q.push_back(rand_byte());
        if ($urandom_range(0, 9) != 0) stim_q.push_back(EOFB);
      end
      stim_q.push_back(EOFB);
      model_run();
      got_q.delete();
      err_seen = 0;
      base_ok  = frame_ok_cnt;
      base_err = frame_err_cnt;
      apply_stimulus(1'b1);
      compare_run($sformatf("rand%0d", r));
`ifdef RX_STATS_EN
      check_output($sformatf("rand%0d_ok_cnt", r), int'(16'(frame_ok_cnt - base_ok)), exp_ok);
      check_output($sformatf("rand%0d_err_cnt", r), int'(16'(frame_err_cnt - base_err)), exp_err);
`else
      check_output($sformatf("rand%0d_ok_cnt", r), int'(frame_ok_cnt), 0);
      check_output($sformatf("rand%0d_err_cnt", r), int'(frame_err_cnt), 0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
